// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32 frame checker: strips the 4-byte FCS and checks it.
// Define CRC_CHECK_STATS_EN to add saturating good/bad frame counters.
module crc32_frame_checker #(
    parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
`ifdef CRC_CHECK_STATS_EN
    ,
    parameter int          CNT_W      = 16
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        done_port,
    output logic        crc_ok,
    output logic        runt,
    output logic [31:0] return_port
`ifdef CRC_CHECK_STATS_EN
    ,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] bad_count
`endif
);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, CHECK} state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] crc;
    logic [2:0]  cnt;
    logic [7:0]  b0, b1, b2, b3;
    logic        accept;
    logic        check;
    logic [31:0] fcs;
    logic [31:0] result;
    logic        short_frame;
    logic        frame_ok;

    assign fcs         = {b3, b2, b1, b0};
    assign result      = crc ^ CRC_XOROUT;
    assign short_frame = cnt < 3'd5;
    assign frame_ok    = (result == fcs) && !short_frame;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        check   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_port) state_n = PRIME;
            end
            PRIME, STREAM: begin
                if (start_port) begin
                    state_n = PRIME;
                end else if (in_valid) begin
                    accept = 1'b1;
                    if (in_last) begin
                        state_n = CHECK;
                    end else if (cnt == 3'd3) begin
                        state_n = STREAM;
                    end
                end
            end
            CHECK: begin
                if (start_port) begin
                    state_n = PRIME;
                end else begin
                    state_n = IDLE;
                    check   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crc         <= CRC_INIT;
            cnt         <= 3'd0;
            b0          <= 8'h0;
            b1          <= 8'h0;
            b2          <= 8'h0;
            b3          <= 8'h0;
            out_valid   <= 1'b0;
            out_data    <= 8'h0;
            out_last    <= 1'b0;
            done_port   <= 1'b0;
            crc_ok      <= 1'b0;
            runt        <= 1'b0;
            return_port <= 32'h0;
`ifdef CRC_CHECK_STATS_EN
            good_count  <= '0;
            bad_count   <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done_port <= 1'b0;
            if (start_port) begin
                crc         <= CRC_INIT;
                cnt         <= 3'd0;
                b0          <= 8'h0;
                b1          <= 8'h0;
                b2          <= 8'h0;
                b3          <= 8'h0;
                crc_ok      <= 1'b0;
                runt        <= 1'b0;
                return_port <= 32'h0;
            end else if (accept) begin
                b0 <= b1;
                b1 <= b2;
                b2 <= b3;
                b3 <= in_data;
                if (cnt != 3'd5) cnt <= cnt + 3'd1;
                // Once the buffer is full every displaced byte is payload
                if (state == STREAM) begin
                    crc       <= crc_byte(crc, b0);
                    out_valid <= 1'b1;
                    out_data  <= b0;
                    out_last  <= in_last;
                end
            end else if (check) begin
                done_port   <= 1'b1;
                return_port <= result;
                runt        <= short_frame;
                crc_ok      <= frame_ok;
`ifdef CRC_CHECK_STATS_EN
                if (frame_ok) begin
                    if (good_count != {CNT_W{1'b1}}) begin
                        good_count <= good_count + CNT_W'(1);
                    end
                end else if (bad_count != {CNT_W{1'b1}}) begin
                    bad_count <= bad_count + CNT_W'(1);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Randomised self-checking bench for crc32_frame_checker.
// Frames are checked against a queue-based reference model.
module tb_crc32_frame_checker;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        start_port;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        done_port;
    logic        crc_ok;
    logic        runt;
    logic [31:0] return_port;
`ifdef CRC_CHECK_STATS_EN
    logic [15:0] good_count;
    logic [15:0] bad_count;
`endif

    crc32_frame_checker dut (
        .clock       (clock),
        .reset       (rst_n),
        .start_port  (start_port),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .done_port   (done_port),
        .crc_ok      (crc_ok),
        .runt        (runt),
        .return_port (return_port)
`ifdef CRC_CHECK_STATS_EN
        ,
        .good_count  (good_count),
        .bad_count   (bad_count)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    logic [8:0]  obs_q[$];
    logic [8:0]  exp_q[$];
    logic [7:0]  frm[$];
    int          done_cnt;
    int          done_cyc;
    int          last_out_cyc;
    int          drv_last_cyc;
    logic [31:0] done_ret;
    logic        done_ok;
    logic        done_runt;
    logic [31:0] exp_ret;
    logic        exp_ok;
    logic        exp_runt;

    always @(negedge clock) begin
        if (out_valid) begin
            obs_q.push_back({out_last, out_data});
            if (out_last) last_out_cyc = cyc;
        end
        if (done_port) begin
            done_cnt++;
            done_cyc  = cyc;
            done_ret  = return_port;
            done_ok   = crc_ok;
            done_runt = runt;
        end
    end

    // Plain bitwise reflected CRC-32 over the first n bytes of frm
    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) begin
                if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
                else      c = c >> 1;
            end
        end
        return ~c;
    endfunction

    function automatic void model_frame();
        int n;
        n = frm.size();
        exp_q.delete();
        if (n < 5) begin
            exp_runt = 1'b1;
            exp_ok   = 1'b0;
            exp_ret  = 32'h0;
        end else begin
            for (int i = 0; i < n - 4; i++) begin
                exp_q.push_back({1'(i == n - 5), frm[i]});
            end
            exp_ret  = ref_crc(n - 4);
            exp_runt = 1'b0;
            exp_ok   = exp_ret ==
                {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
        end
    endfunction

    function automatic bit obs_is_exp();
        if (obs_q.size() != exp_q.size()) return 1'b0;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic clear_obs();
        obs_q.delete();
        done_cnt     = 0;
        done_cyc     = -1;
        last_out_cyc = -1;
    endtask

    task automatic build_std(input logic [7:0] last_byte);
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        frm.push_back(8'h26);
        frm.push_back(8'h39);
        frm.push_back(8'hF4);
        frm.push_back(last_byte);
    endtask

    // Junk byte with in_valid and in_last on the start cycle must be ignored
    task automatic pulse_start();
        @(negedge clock);
        start_port = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'($urandom);
        in_last    = 1'b1;
        @(negedge clock);
        start_port = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic drive_frame(input int gap_pct, input int nbytes,
                               input bit start_after);
        for (int i = 0; i < nbytes; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                @(negedge clock);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
            end
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = frm[i];
            in_last  = (i == frm.size() - 1);
            if (in_last) drv_last_cyc = cyc;
        end
        @(negedge clock);
        in_valid   = 1'b0;
        in_last    = 1'b0;
        start_port = start_after;
        if (start_after) begin
            @(negedge clock);
            start_port = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start_port = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'hA5;
        in_last    = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if ({out_valid, out_data, out_last, done_port,
             crc_ok, runt, return_port} !== 44'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %b %h %b %b %b %b %h want 0",
                     out_valid, out_data, out_last, done_port,
                     crc_ok, runt, return_port);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_good_frame();
        build_std(8'hCB);
        model_frame();
        clear_obs();
        pulse_start();
        drive_frame(0, 13, 1'b0);
        repeat (4) @(negedge clock);
        tests++;
        if (!obs_is_exp()) begin
            fails++;
            $display("FAIL good_payload: got %0d bytes want %0d",
                     obs_q.size(), exp_q.size());
        end
        tests++;
        if (last_out_cyc !== drv_last_cyc + 1) begin
            fails++;
            $display("FAIL good_last_lat: got %0d want %0d",
                     last_out_cyc, drv_last_cyc + 1);
        end
        tests++;
        if (done_cnt !== 1 || done_cyc !== drv_last_cyc + 2) begin
            fails++;
            $display("FAIL good_done: got n=%0d cyc=%0d want 1 cyc=%0d",
                     done_cnt, done_cyc, drv_last_cyc + 2);
        end
        tests++;
        if ({done_ret, done_ok, done_runt} !== {32'hCBF43926, 2'b10}) begin
            fails++;
            $display("FAIL good_result: got %h ok=%b runt=%b want cbf43926 1 0",
                     done_ret, done_ok, done_runt);
        end
        tests++;
        if ({return_port, crc_ok, runt} !== {32'hCBF43926, 2'b10}) begin
            fails++;
            $display("FAIL good_held: got %h %b %b want cbf43926 1 0",
                     return_port, crc_ok, runt);
        end
    endtask

    task automatic test_bad_fcs();
        build_std(8'hCA);
        model_frame();
        clear_obs();
        pulse_start();
        drive_frame(0, 13, 1'b0);
        repeat (4) @(negedge clock);
        tests++;
        if (!obs_is_exp()) begin
            fails++;
            $display("FAIL bad_payload: got %0d bytes want %0d",
                     obs_q.size(), exp_q.size());
        end
        tests++;
        if (done_cnt !== 1 ||
            {done_ret, done_ok, done_runt} !== {32'hCBF43926, 2'b00}) begin
            fails++;
            $display("FAIL bad_result: got n=%0d %h ok=%b runt=%b want 1 cbf43926 0 0",
                     done_cnt, done_ret, done_ok, done_runt);
        end
    endtask

    task automatic test_runt();
        frm.delete();
        for (int i = 0; i < 3; i++) frm.push_back(8'($urandom));
        clear_obs();
        pulse_start();
        drive_frame(20, 3, 1'b0);
        repeat (4) @(negedge clock);
        tests++;
        if (obs_q.size() !== 0) begin
            fails++;
            $display("FAIL runt_payload: got %0d bytes want 0", obs_q.size());
        end
        tests++;
        if (done_cnt !== 1 ||
            {done_ret, done_ok, done_runt} !== {32'h0, 2'b01}) begin
            fails++;
            $display("FAIL runt_result: got n=%0d %h ok=%b runt=%b want 1 0 0 1",
                     done_cnt, done_ret, done_ok, done_runt);
        end
    endtask

    task automatic test_abort_restart();
        build_std(8'hCB);
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h31});
        exp_q.push_back({1'b0, 8'h32});
        for (int i = 0; i < 9; i++) exp_q.push_back({1'(i == 8), frm[i]});
        clear_obs();
        pulse_start();
        drive_frame(30, 6, 1'b0);
        pulse_start();
        drive_frame(30, 13, 1'b0);
        repeat (4) @(negedge clock);
        tests++;
        if (!obs_is_exp()) begin
            fails++;
            $display("FAIL abort_payload: got %0d bytes want %0d",
                     obs_q.size(), exp_q.size());
        end
        tests++;
        if (done_cnt !== 1 || done_ok !== 1'b1 || done_runt !== 1'b0) begin
            fails++;
            $display("FAIL abort_result: got n=%0d ok=%b runt=%b want 1 1 0",
                     done_cnt, done_ok, done_runt);
        end
        // start arriving in the check cycle suppresses the result
        model_frame();
        clear_obs();
        pulse_start();
        drive_frame(0, 13, 1'b1);
        repeat (4) @(negedge clock);
        tests++;
        if (done_cnt !== 0 || !obs_is_exp()) begin
            fails++;
            $display("FAIL abort_in_check: got done=%0d bytes=%0d want 0 9",
                     done_cnt, obs_q.size());
        end
        clear_obs();
        drive_frame(10, 13, 1'b0);
        repeat (4) @(negedge clock);
        tests++;
        if (done_cnt !== 1 || done_ok !== 1'b1 || !obs_is_exp()) begin
            fails++;
            $display("FAIL rearm_after_check: got n=%0d ok=%b bytes=%0d want 1 1 9",
                     done_cnt, done_ok, obs_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        build_std(8'hCB);
        clear_obs();
        pulse_start();
        drive_frame(0, 6, 1'b0);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h32) begin
            fails++;
            $display("FAIL pre_reset_out: got %b %h want 1 32",
                     out_valid, out_data);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_data, out_last, done_port,
             crc_ok, runt, return_port} !== 44'h0) begin
            fails++;
            $display("FAIL midframe_reset: got %b %h %b %b %b %b %h want 0",
                     out_valid, out_data, out_last, done_port,
                     crc_ok, runt, return_port);
        end
        @(negedge clock);
        rst_n = 1'b1;
        model_frame();
        clear_obs();
        pulse_start();
        drive_frame(0, 13, 1'b0);
        repeat (4) @(negedge clock);
        tests++;
        if (done_cnt !== 1 || done_ok !== 1'b1 || !obs_is_exp()) begin
            fails++;
            $display("FAIL after_reset_frame: got n=%0d ok=%b bytes=%0d want 1 1 9",
                     done_cnt, done_ok, obs_q.size());
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 40; f++) begin
            int          n;
            logic [31:0] c;
            n = $urandom_range(1, 16);
            frm.delete();
            for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
            if (n >= 5 && $urandom_range(1) == 1) begin
                c = ref_crc(n - 4);
                frm[n-4] = c[7:0];
                frm[n-3] = c[15:8];
                frm[n-2] = c[23:16];
                frm[n-1] = c[31:24];
            end
            model_frame();
            clear_obs();
            pulse_start();
            drive_frame($urandom_range(0, 50), n, 1'b0);
            repeat (4) @(negedge clock);
            tests++;
            if (!obs_is_exp()) begin
                fails++;
                $display("FAIL rand_payload[%0d]: len=%0d got %0d bytes want %0d",
                         f, n, obs_q.size(), exp_q.size());
            end
            tests++;
            if (done_cnt !== 1 || done_cyc !== drv_last_cyc + 2) begin
                fails++;
                $display("FAIL rand_done[%0d]: got n=%0d cyc=%0d want 1 cyc=%0d",
                         f, done_cnt, done_cyc, drv_last_cyc + 2);
            end
            tests++;
            if ({done_ret, done_ok, done_runt} !==
                {exp_ret, exp_ok, exp_runt}) begin
                fails++;
                $display("FAIL rand_result[%0d]: len=%0d got %h %b %b want %h %b %b",
                         f, n, done_ret, done_ok, done_runt,
                         exp_ret, exp_ok, exp_runt);
            end
        end
    endtask

`ifdef CRC_CHECK_STATS_EN
    task automatic test_stats();
        @(negedge clock);
        rst_n = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        tests++;
        if (good_count !== 16'd0 || bad_count !== 16'd0) begin
            fails++;
            $display("FAIL stats_reset: got %0d %0d want 0 0",
                     good_count, bad_count);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                frm.delete();
                for (int i = 0; i < 3; i++) frm.push_back(8'($urandom));
            end else begin
                build_std(k == 2 ? 8'hCA : 8'hCB);
            end
            pulse_start();
            drive_frame(10, frm.size(), 1'b0);
            repeat (4) @(negedge clock);
        end
        tests++;
        if (good_count !== 16'd2 || bad_count !== 16'd2) begin
            fails++;
            $display("FAIL stats_counts: got %0d %0d want 2 2",
                     good_count, bad_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_runt();
        test_abort_restart();
        test_reset_midframe();
        test_random_frames();
`ifdef CRC_CHECK_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
